hazard_scoreboard: RTL and testbench

- Parametrised Tuse/Tnew hazard and forwarding controller for the 5-stage pipeline (F/D/E/M/W). It supersedes the fixed stall-and-forward logic.
- It keeps its own registered scoreboard of the E, M and W stage destinations, so the datapath only presents D-stage decode info each cycle.
- It outputs a stall request and the forwarding mux selects for D, E and M operands.
- It adds a multiply/divide busy counter with distinct, parametrised latencies.

---
 rtl/hazard_scoreboard.sv | 185 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard and forwarding controller for a 5-stage F/D/E/M/W pipeline.
// Keeps its own E/M/W destination scoreboard plus a mult/div busy counter.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic              d_we,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_use,
  input  logic              e_md_start,
  input  logic              e_md_div,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic              fwd_m_rt,
  output logic              md_busy
);

  localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int MDW    = $clog2(MD_MAX + 1);

  typedef logic [REG_AW-1:0] reg_t;
  typedef logic [TW-1:0]     t_t;

  // Scoreboard: one slot per stage; tnew is already aged for the stage it sits in.
  reg_t e_dst, e_rs, e_rt;
  logic e_we;
  t_t   e_tnew;

  reg_t m_dst, m_rs, m_rt;
  logic m_we;
  t_t   m_tnew;

  reg_t w_dst;
  logic w_we;
  t_t   w_tnew;

  logic [MDW-1:0] md_cnt;

  function automatic t_t sat_dec(input t_t t);
    sat_dec = (t == '0) ? '0 : t - t_t'(1);
  endfunction

  function automatic logic hit(input logic we, input reg_t dst, input reg_t r);
    hit = we && (dst != '0) && (dst == r);
  endfunction

  // Nearest matching stage wins; a match whose result is not ready yet selects GRF.
  function automatic logic [1:0] sel_d(input logic he, input logic hm, input logic hw,
                                       input t_t tn_e, input t_t tn_m, input t_t tn_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (he) begin
      if (tn_e == '0) sel = 2'd1;
    end else if (hm) begin
      if (tn_m == '0) sel = 2'd2;
    end else if (hw) begin
      if (tn_w == '0) sel = 2'd3;
    end
    return sel;
  endfunction

  function automatic logic [1:0] sel_e(input logic hm, input logic hw, input t_t tn_m);
    logic [1:0] sel;
    sel = 2'd0;
    if (hm) begin
      if (tn_m == '0) sel = 2'd1;
    end else if (hw) begin
      sel = 2'd2;
    end
    return sel;
  endfunction

  // D-stage source matches against each scoreboard slot.
  logic e_hit_rs, m_hit_rs, w_hit_rs;
  logic e_hit_rt, m_hit_rt, w_hit_rt;

  assign e_hit_rs = hit(e_we, e_dst, d_rs);
  assign m_hit_rs = hit(m_we, m_dst, d_rs);
  assign w_hit_rs = hit(w_we, w_dst, d_rs);
  assign e_hit_rt = hit(e_we, e_dst, d_rt);
  assign m_hit_rt = hit(m_we, m_dst, d_rt);
  assign w_hit_rt = hit(w_we, w_dst, d_rt);

  // A producer is too late when its remaining tnew exceeds the consumer's tuse.
  logic late_rs, late_rt, md_block;

  assign late_rs = (d_tuse_rs != '1) &&
                   ((e_hit_rs && (e_tnew > d_tuse_rs)) ||
                    (m_hit_rs && (m_tnew > d_tuse_rs)) ||
                    (w_hit_rs && (w_tnew > d_tuse_rs)));

  assign late_rt = (d_tuse_rt != '1) &&
                   ((e_hit_rt && (e_tnew > d_tuse_rt)) ||
                    (m_hit_rt && (m_tnew > d_tuse_rt)) ||
                    (w_hit_rt && (w_tnew > d_tuse_rt)));

  assign md_busy  = (md_cnt != '0);
  assign md_block = d_md_use && (md_busy || e_md_start);
  assign stall    = late_rs || late_rt || md_block;

  assign fwd_d_rs = sel_d(e_hit_rs, m_hit_rs, w_hit_rs, e_tnew, m_tnew, w_tnew);
  assign fwd_d_rt = sel_d(e_hit_rt, m_hit_rt, w_hit_rt, e_tnew, m_tnew, w_tnew);

  // E-stage operands look back into M and W.
  logic me_hit_rs, we_hit_rs, me_hit_rt, we_hit_rt;

  assign me_hit_rs = hit(m_we, m_dst, e_rs);
  assign we_hit_rs = hit(w_we, w_dst, e_rs);
  assign me_hit_rt = hit(m_we, m_dst, e_rt);
  assign we_hit_rt = hit(w_we, w_dst, e_rt);

  assign fwd_e_rs = sel_e(me_hit_rs, we_hit_rs, m_tnew);
  assign fwd_e_rt = sel_e(me_hit_rt, we_hit_rt, m_tnew);

  assign fwd_m_rt = hit(w_we, w_dst, m_rt) && (w_tnew == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_dst  <= '0;
      e_we   <= 1'b0;
      e_tnew <= '0;
      e_rs   <= '0;
      e_rt   <= '0;
      m_dst  <= '0;
      m_we   <= 1'b0;
      m_tnew <= '0;
      m_rs   <= '0;
      m_rt   <= '0;
      w_dst  <= '0;
      w_we   <= 1'b0;
      w_tnew <= '0;
    end else begin
      w_dst  <= m_dst;
      w_we   <= m_we;
      w_tnew <= sat_dec(m_tnew);
      m_dst  <= e_dst;
      m_we   <= e_we;
      m_tnew <= sat_dec(e_tnew);
      m_rs   <= e_rs;
      m_rt   <= e_rt;
      // A stalled or flushed D instruction leaves a bubble behind in E.
      if (stall || flush) begin
        e_dst  <= '0;
        e_we   <= 1'b0;
        e_tnew <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end else begin
        e_dst  <= d_dst;
        e_we   <= d_we;
        e_tnew <= d_tnew;
        e_rs   <= d_rs;
        e_rt   <= d_rt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (e_md_start) begin
      md_cnt <= e_md_div ? MDW'(DIV_CYC) : MDW'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MDW'(1);
    end
  end

  // rs in M is carried for visibility only; nothing downstream consumes it.
  logic unused_m_rs;
  assign unused_m_rs = ^m_rs;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: the driver pushes predicted outputs from a
// stage-age reference model, an independent monitor pops and compares every cycle.
module tb_hazard_scoreboard;

  localparam int REG_AW   = 5;
  localparam int TW       = 2;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [REG_AW-1:0] d_rs = '0, d_rt = '0, d_dst = '0;
  logic [TW-1:0]     d_tuse_rs = '1, d_tuse_rt = '1, d_tnew = '0;
  logic              d_we = 1'b0, d_md_use = 1'b0, e_md_start = 1'b0, e_md_div = 1'b0, flush = 1'b0;
  logic              stall, fwd_m_rt, md_busy;
  logic [1:0]        fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW(REG_AW), .TW(TW), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_we(d_we), .d_tnew(d_tnew), .d_md_use(d_md_use),
    .e_md_start(e_md_start), .e_md_div(e_md_div), .flush(flush),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_busy(md_busy)
  );

  // Reference model: each in-flight instruction keeps the tnew it had on entering E;
  // its remaining latency in slot s (0=E, 1=M, 2=W) is max(0, tnew - s).
  typedef struct {
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              we;
    int                tnew;
  } slot_t;

  slot_t pipe[3];
  int    cyc = 0;
  int    md_end = 0;

  // {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy}
  logic [10:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  function automatic int remaining(int s);
    return (pipe[s].tnew - s > 0) ? pipe[s].tnew - s : 0;
  endfunction

  function automatic bit writes(int s, logic [REG_AW-1:0] r);
    return pipe[s].we && (pipe[s].dst != 0) && (pipe[s].dst == r);
  endfunction

  function automatic bit waits_on(logic [REG_AW-1:0] r, int tuse);
    if (tuse == 3) return 1'b0;
    for (int s = 0; s < 3; s++)
      if (writes(s, r) && remaining(s) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] d_src(logic [REG_AW-1:0] r);
    for (int s = 0; s < 3; s++)
      if (writes(s, r)) return (remaining(s) == 0) ? 2'(s + 1) : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] e_src(logic [REG_AW-1:0] r);
    if (writes(1, r)) return (remaining(1) == 0) ? 2'd1 : 2'd0;
    if (writes(2, r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [10:0] predict();
    logic busy, st, fm;
    busy = (cyc < md_end);
    st = waits_on(d_rs, int'(d_tuse_rs)) || waits_on(d_rt, int'(d_tuse_rt)) ||
         (d_md_use && (busy || e_md_start));
    fm = writes(2, pipe[1].rt) && (remaining(2) == 0);
    return {st, d_src(d_rs), d_src(d_rt), e_src(pipe[0].rs), e_src(pipe[0].rt), fm, busy};
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      pipe[s].dst = '0; pipe[s].rs = '0; pipe[s].rt = '0; pipe[s].we = 1'b0; pipe[s].tnew = 0;
    end
    md_end = 0;
  endtask

  task automatic model_advance(input logic st);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (st || flush) begin
      pipe[0].dst = '0; pipe[0].rs = '0; pipe[0].rt = '0; pipe[0].we = 1'b0; pipe[0].tnew = 0;
    end else begin
      pipe[0].dst = d_dst; pipe[0].rs = d_rs; pipe[0].rt = d_rt;
      pipe[0].we = d_we; pipe[0].tnew = int'(d_tnew);
    end
    if (e_md_start) md_end = cyc + 1 + (e_md_div ? DIV_CYC : MULT_CYC);
    cyc++;
  endtask

  // One clock of D-stage stimulus; st returns the model's stall decision.
  task automatic drive(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [TW-1:0] urs, input logic [TW-1:0] urt,
                       input logic [REG_AW-1:0] dst, input logic we, input logic [TW-1:0] tnew,
                       input logic mduse, input logic mds, input logic mdd, input logic fl,
                       output logic st);
    logic [10:0] e;
    @(negedge clk);
    #1;
    d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_dst = dst; d_we = we; d_tnew = tnew;
    d_md_use = mduse; e_md_start = mds; e_md_div = mdd; flush = fl;
    reset = 1'b1;
    e = predict();
    exp_q.push_back(e);
    st = e[10];
    model_advance(e[10]);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      d_rs = '0; d_rt = '0; d_tuse_rs = '1; d_tuse_rt = '1; d_dst = '0; d_we = 1'b0;
      d_tnew = '0; d_md_use = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0; flush = 1'b0;
      reset = 1'b0;
      model_clear();
      exp_q.push_back(11'd0);
    end
  endtask

  // Present an instruction in D and hold it there while the model says it stalls.
  task automatic issue(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [TW-1:0] urs, input logic [TW-1:0] urt,
                       input logic [REG_AW-1:0] dst, input logic we, input logic [TW-1:0] tnew,
                       input logic mduse, input logic mds, input logic mdd);
    logic st;
    int   tries;
    tries = 0;
    drive(rs, rt, urs, urt, dst, we, tnew, mduse, mds, mdd, 1'b0, st);
    while (st && tries < 30) begin
      drive(rs, rt, urs, urt, dst, we, tnew, mduse, 1'b0, 1'b0, 1'b0, st);
      tries++;
    end
  endtask

  task automatic nop(input int n);
    logic st;
    repeat (n) drive('0, '0, 2'd3, 2'd3, '0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
  endtask

  // Monitor: compares whatever the DUT shows against the oldest prediction.
  initial begin
    logic [10:0] e, a;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy};
        checks++;
        if (a === e) passes++;
        else $display("FAIL outputs t=%0t: got stall=%b fd_rs=%0d fd_rt=%0d fe_rs=%0d fe_rt=%0d fm_rt=%b busy=%b, expected stall=%b fd_rs=%0d fd_rt=%0d fe_rs=%0d fe_rt=%0d fm_rt=%b busy=%b",
                      $time, a[10], a[9:8], a[7:6], a[5:4], a[3:2], a[1], a[0],
                      e[10], e[9:8], e[7:6], e[5:4], e[3:2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic st;
    model_clear();
    do_reset(2);
    nop(2);

    // Load-use: lw $1 (tnew 2) then addu reading $1 at tuse 1.
    issue(5'd1, 5'd0, 2'd3, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nop(3);

    // ALU result feeding a branch compare in D.
    issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    issue(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    nop(3);

    // jal $31 then jr $31.
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    issue(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    nop(3);

    // Writes to $0 are never hazards.
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    issue(5'd0, 5'd0, 2'd0, 2'd0, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nop(3);

    // Store data: lw $5, nop, sw rt=$5.
    issue(5'd6, 5'd0, 2'd1, 2'd3, 5'd5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    nop(1);
    issue(5'd6, 5'd5, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    nop(4);

    // Divide start with mfhi waiting in D, then multiply with mflo.
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
    nop(2);
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    nop(2);

    // Reset in the middle of a divide drops md_busy at once.
    drive('0, '0, 2'd3, 2'd3, '0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, st);
    nop(4);
    do_reset(1);
    nop(3);

    // Simultaneous flush and mult/div stall.
    drive(5'd1, 5'd0, 2'd3, 2'd3, 5'd2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, st);
    nop(8);

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(1);
      end else begin
        drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), st);
      end
    end

    repeat (3) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
